// File: rtl/uart_pkg.sv
// Frame constants and receiver state encoding shared by the UART RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to a chosen level.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic system_clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_phy_fsm.sv
// 8N1 UART receiver: oversamples rx on clock_enable ticks, emits one-cycle
// rx_valid / framing_error pulses and counts good bytes.
module uart_rx_phy_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 17
) (
  input  logic             system_clock,
  input  logic             rst,
  input  logic             clock_enable,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             framing_error,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(UART_DATA_BITS + 1);
  localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(UART_DATA_BITS - 1);

  rx_state_t          state, state_next;
  logic [SCNT_W-1:0]  sample_cnt, sample_cnt_next;
  logic [BCNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [7:0]         shift_reg, shift_next;
  logic [7:0]         rx_data_next;
  logic               rx_valid_next, framing_error_next;
  logic [CNT_W-1:0]   byte_count_next;
  logic               rx_s;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .system_clock (system_clock),
    .rst          (rst),
    .d            (rx),
    .q            (rx_s)
  );

  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sample_cnt    <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      byte_count    <= '0;
    end else begin
      state         <= state_next;
      sample_cnt    <= sample_cnt_next;
      bit_cnt       <= bit_cnt_next;
      shift_reg     <= shift_next;
      rx_data       <= rx_data_next;
      rx_valid      <= rx_valid_next;
      framing_error <= framing_error_next;
      byte_count    <= byte_count_next;
    end
  end

  // Pulses default low every cycle so they last one clock even between ticks.
  always_comb begin
    state_next         = state;
    sample_cnt_next    = sample_cnt;
    bit_cnt_next       = bit_cnt;
    shift_next         = shift_reg;
    rx_data_next       = rx_data;
    byte_count_next    = byte_count;
    rx_valid_next      = 1'b0;
    framing_error_next = 1'b0;

    if (clock_enable) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_next      = START;
            sample_cnt_next = '0;
          end
        end
        START: begin
          if (sample_cnt == HALF_LAST) begin
            sample_cnt_next = '0;
            bit_cnt_next    = '0;
            state_next      = rx_s ? IDLE : DATA;
          end else begin
            sample_cnt_next = sample_cnt + SCNT_W'(1);
          end
        end
        DATA: begin
          if (sample_cnt == FULL_LAST) begin
            shift_next      = {rx_s, shift_reg[7:1]};
            sample_cnt_next = '0;
            bit_cnt_next    = bit_cnt + BCNT_W'(1);
            if (bit_cnt == LAST_BIT) state_next = STOP;
          end else begin
            sample_cnt_next = sample_cnt + SCNT_W'(1);
          end
        end
        STOP: begin
          if (sample_cnt == FULL_LAST) begin
            sample_cnt_next = '0;
            if (rx_s) begin
              rx_data_next    = shift_reg;
              rx_valid_next   = 1'b1;
              byte_count_next = byte_count + CNT_W'(1);
              state_next      = IDLE;
            end else begin
              framing_error_next = 1'b1;
              state_next         = WAIT_IDLE;
            end
          end else begin
            sample_cnt_next = sample_cnt + SCNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
